morphle_wb_driver: RTL
======================

Name: morphle_wb_driver

Overview:
- Wishbone slave that drives one 16x16 Morphle yblock from the management SoC, replacing logic-analyzer stimulus with on-chip register access.
- Holds the block reset, configuration enable, configuration data and input vectors.
- Generates configuration clock pulses.
- Samples the asynchronous yblock outputs after a programmable settle time.
- Sits inside the user project, between the Wishbone port and the yblock.

Parameters:
- CFG_W, 8, width of the configuration data bus into the yblock.
- IN_W, 32, width of the yblock input vector (left/up edge inputs).
- OUT_W, 32, width of the yblock output vector.
- PULSE_CYC, 2, clock cycles each confclk phase (high, then low) lasts; minimum 1.
- SETTLE_W, 8, width of the settle counter.

Ports:
- wb_clk_i  in  1  system clock; every flop in this block uses it.
- wb_rst_ni  in  1  synchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; all four are required for a write to take effect.
- wbs_adr_i  in  32  byte address; bits [4:2] select the register.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  read data.
- ys_reset  out  1  yblock reset.
- ys_confena  out  1  yblock configuration enable.
- ys_confclk  out  1  yblock configuration clock.
- ys_cfg  out  CFG_W  yblock configuration data.
- ys_in  out  IN_W  yblock input vector.
- ys_out  in  OUT_W  yblock outputs; asynchronous, and captured only through the two-flop stage.
- busy_o  out  1  high while the FSM is not in IDLE.

Behaviour:
- Register map (wbs_adr_i[4:2]):
  - 0 CTRL (rw): bit0 blk_reset, bit1 conf_ena.
  - 1 CFG (rw): cfg[CFG_W-1:0].
  - 2 IN (rw): in[IN_W-1:0].
  - 3 CMD (wo, reads 0): bit0 CONF_PULSE, bit1 SAMPLE.
  - 4 SETTLE (rw): settle count.
  - 5 STATUS (ro): bit0 busy, bit1 valid, bit2 err.
  - 6 OUT (ro): captured output.
  - 7: reads 0, writes ignored.
- Wishbone handshake:
  - wbs_ack_o rises exactly one cycle after a cycle with stb&cyc&!ack, for one cycle only.
  - Every access is acked; there are no wait states and no error ack.
  - Writes commit on the cycle ack is asserted.
  - wbs_dat_o is valid while ack is high and is 0 otherwise.
- Output mapping:
  - ys_reset = blk_reset; ys_confena = conf_ena; ys_cfg = CFG register; ys_in = IN register.
  - All are registered; a write is visible the cycle after its ack.
- Reset values:
  - blk_reset = 1, so the yblock is held in reset.
  - conf_ena = 0, CFG = 0, IN = 0, SETTLE = 4, OUT = 0.
  - valid = 0, err = 0, ys_confclk = 0, wbs_ack_o = 0, busy_o = 0.
  - FSM = IDLE.
  - A reset in mid-operation aborts the FSM to IDLE and drops ys_confclk low in the same cycle the reset is sampled.
- Input capture:
  - ys_out passes through a 2-flop synchronizer.
  - OUT is loaded from the synchronizer output only in the CAPTURE state.
- FSM states and transitions:
  - IDLE:
    - A CMD write with bit0=1 goes to CLK_HI.
    - Otherwise, a CMD write with bit1=1 goes to SETTLE and loads the counter from SETTLE.
    - If both bits are set, CONF_PULSE runs first and SAMPLE follows automatically after CLK_LO.
  - CLK_HI: ys_confclk=1 for PULSE_CYC cycles, then go to CLK_LO.
  - CLK_LO: ys_confclk=0 for PULSE_CYC cycles, then go to SETTLE if a sample is pending, else IDLE.
  - SETTLE: the counter decrements once per cycle; at 0, go to CAPTURE. SETTLE=0 means one cycle in SETTLE.
  - CAPTURE: load OUT, set valid, return to IDLE. This state lasts one cycle.
- Command handling rules:
  - A CMD write while busy is ignored and sets err (sticky).
  - err is cleared by writing 1 to STATUS bit2 (write-1-to-clear).
  - valid clears on a read of OUT; if capture and the read happen in the same cycle, the capture wins and valid stays 1.
  - CTRL, CFG and IN writes are accepted while busy and take effect immediately.
  - Software must not change CFG during CLK_HI; the hardware does not enforce this.
- Latency:
  - CONF_PULSE only: busy for 2*PULSE_CYC cycles after the ack.
  - SAMPLE only: OUT is updated SETTLE+2 cycles after the ack.

Decomposition:
- Shared package morphle_pkg holds:
  - register index constants REG_CTRL..REG_OUT;
  - the CMD and STATUS bit positions;
  - the FSM state enumeration (IDLE, CLK_HI, CLK_LO, SETTLE, CAPTURE).
- One natural sub-module: morphle_conf_seq, containing the FSM, pulse counter, settle counter and capture.
- The register file and Wishbone logic stay in the top module.

Test Plan:
- Reset: hold wb_rst_ni=0 for 3 cycles, then read CTRL and STATUS -> CTRL=0x1, STATUS=0x0, ys_confclk=0, OUT=0.
- Configuration pulse: write CTRL=0x2, CFG=0xA5, CMD=0x1 (PULSE_CYC=2) -> ys_cfg=0xA5, ys_confclk high for exactly 2 cycles then low for 2; busy_o drops 4 cycles after the ack.
- Sample: write SETTLE=3, tie ys_out=0xDEADBEEF, write CMD=0x2 -> STATUS.valid=1 exactly 5 cycles after the ack; OUT reads 0xDEADBEEF; a second STATUS read shows valid=0.
- Combined command: write CMD=0x3 -> one confclk pulse, then a sample; OUT is updated 2*PULSE_CYC+SETTLE+2 cycles after the ack.
- Busy collision: write CMD=0x1, then CMD=0x2 during CLK_HI -> only one pulse, no sample, STATUS.err=1; writing STATUS=0x4 then reads err=0.
- Reset mid-pulse: assert wb_rst_ni=0 during CLK_HI -> the next cycle has ys_confclk=0, busy_o=0 and blk_reset=1.

Source files
------------

// File: rtl/morphle_pkg.sv
// Shared definitions for the Morphle yblock Wishbone driver.
// Register indices, bit positions and sequencer states.
package morphle_pkg;

    // Register indices decoded from wbs_adr_i[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_CFG    = 3'd1;
    localparam logic [2:0] REG_IN     = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_SETTLE = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [2:0] REG_OUT    = 3'd6;

    // CTRL bit positions
    localparam int CTRL_RST = 0;
    localparam int CTRL_ENA = 1;

    // CMD bit positions
    localparam int CMD_PULSE  = 0;
    localparam int CMD_SAMPLE = 1;

    // STATUS bit positions
    localparam int ST_BUSY  = 0;
    localparam int ST_VALID = 1;
    localparam int ST_ERR   = 2;

    // Settle count loaded at reset
    localparam int SETTLE_RST = 4;

    // Configuration / sampling sequencer states
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLK_HI,
        S_CLK_LO,
        S_SETTLE,
        S_CAPTURE
    } seq_state_e;

endpackage

// File: rtl/morphle_conf_seq.sv
// Configuration-clock pulse generator and settle/capture sequencer
// for the yblock outputs, including the input synchronizer.
module morphle_conf_seq
    import morphle_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int PULSE_CYC = 2,
    parameter int SETTLE_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_pulse_i,
    input  logic                start_sample_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                clr_valid_i,
    input  logic [OUT_W-1:0]    ys_out_i,
    output logic                confclk_o,
    output logic                busy_o,
    output logic                valid_o,
    output logic [OUT_W-1:0]    out_o
);

    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [PW-1:0] PLOAD = PW'(PULSE_CYC - 1);

    seq_state_e          state_q;
    logic [PW-1:0]       pcnt_q;
    logic [SETTLE_W-1:0] scnt_q;
    logic                pend_q;
    logic                confclk_q;
    logic                valid_q;
    logic [OUT_W-1:0]    out_q;
    logic [OUT_W-1:0]    sync1_q;
    logic [OUT_W-1:0]    sync2_q;
    logic                cap_d;

    // The capture happens on the edge that enters CAPTURE
    assign cap_d = (state_q == S_SETTLE) && (scnt_q == '0);

    // Two-flop synchronizer for the asynchronous yblock outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ys_out_i;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer FSM; confclk and OUT are registered so they are
    // already valid during CLK_HI and CAPTURE respectively
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            scnt_q    <= '0;
            pend_q    <= 1'b0;
            confclk_q <= 1'b0;
            out_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_pulse_i) begin
                        state_q   <= S_CLK_HI;
                        confclk_q <= 1'b1;
                        pcnt_q    <= PLOAD;
                        pend_q    <= start_sample_i;
                    end else if (start_sample_i) begin
                        state_q <= S_SETTLE;
                        scnt_q  <= settle_i;
                    end
                end
                S_CLK_HI: begin
                    if (pcnt_q == '0) begin
                        state_q   <= S_CLK_LO;
                        confclk_q <= 1'b0;
                        pcnt_q    <= PLOAD;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                S_CLK_LO: begin
                    if (pcnt_q == '0) begin
                        if (pend_q) begin
                            state_q <= S_SETTLE;
                            scnt_q  <= settle_i;
                            pend_q  <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (scnt_q == '0) begin
                        state_q <= S_CAPTURE;
                        out_q   <= sync2_q;
                    end else begin
                        scnt_q <= scnt_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    confclk_q <= 1'b0;
                end
            endcase
        end
    end

    // Valid flag: a capture beats a same-cycle clear from an OUT read
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (cap_d) begin
            valid_q <= 1'b1;
        end else if (clr_valid_i) begin
            valid_q <= 1'b0;
        end
    end

    assign confclk_o = confclk_q;
    assign busy_o    = (state_q != S_IDLE);
    assign valid_o   = valid_q;
    assign out_o     = out_q;

endmodule

// File: rtl/morphle_wb_driver.sv
// Wishbone slave driving one 16x16 Morphle yblock: register file,
// bus handshake, and the configuration/sampling sequencer.
module morphle_wb_driver
    import morphle_pkg::*;
#(
    parameter int CFG_W     = 8,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 32,
    parameter int PULSE_CYC = 2,
    parameter int SETTLE_W  = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             ys_reset,
    output logic             ys_confena,
    output logic             ys_confclk,
    output logic [CFG_W-1:0] ys_cfg,
    output logic [IN_W-1:0]  ys_in,
    input  logic [OUT_W-1:0] ys_out,
    output logic             busy_o
);

    logic                ack_q;
    logic                ack_d;
    logic                blk_reset_q;
    logic                conf_ena_q;
    logic [CFG_W-1:0]    cfg_q;
    logic [IN_W-1:0]     in_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                err_q;
    logic [2:0]          reg_idx;
    logic                wr_en;
    logic                rd_en;
    logic                wr_cmd;
    logic                cmd_err;
    logic                start_pulse;
    logic                start_sample;
    logic                clr_valid;
    logic                seq_busy;
    logic                seq_valid;
    logic [OUT_W-1:0]    seq_out;
    logic [31:0]         rdata_d;
    logic                unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign reg_idx = wbs_adr_i[4:2];
    assign ack_d   = wbs_stb_i & wbs_cyc_i & ~ack_q;

    // Accesses take effect in the ack cycle; writes need all byte lanes
    assign wr_en = ack_q & wbs_we_i & (wbs_sel_i == 4'hF);
    assign rd_en = ack_q & ~wbs_we_i;

    assign wr_cmd       = wr_en && (reg_idx == REG_CMD);
    assign cmd_err      = wr_cmd & seq_busy;
    assign start_pulse  = wr_cmd & ~seq_busy & wbs_dat_i[CMD_PULSE];
    assign start_sample = wr_cmd & ~seq_busy & wbs_dat_i[CMD_SAMPLE];
    assign clr_valid    = rd_en && (reg_idx == REG_OUT);

    // Single-cycle acknowledge, one cycle after each new request
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    // Control, configuration, input and settle registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            blk_reset_q <= 1'b1;
            conf_ena_q  <= 1'b0;
            cfg_q       <= '0;
            in_q        <= '0;
            settle_q    <= SETTLE_W'(SETTLE_RST);
        end else if (wr_en) begin
            case (reg_idx)
                REG_CTRL: begin
                    blk_reset_q <= wbs_dat_i[CTRL_RST];
                    conf_ena_q  <= wbs_dat_i[CTRL_ENA];
                end
                REG_CFG:    cfg_q    <= wbs_dat_i[CFG_W-1:0];
                REG_IN:     in_q     <= wbs_dat_i[IN_W-1:0];
                REG_SETTLE: settle_q <= wbs_dat_i[SETTLE_W-1:0];
                default: ;
            endcase
        end
    end

    // Sticky command-collision flag, write-1-to-clear via STATUS
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            err_q <= 1'b0;
        end else if (cmd_err) begin
            err_q <= 1'b1;
        end else if (wr_en && (reg_idx == REG_STATUS)
                     && wbs_dat_i[ST_ERR]) begin
            err_q <= 1'b0;
        end
    end

    // Read mux; the bus reads zero outside the ack cycle
    always_comb begin
        rdata_d = '0;
        if (ack_q) begin
            case (reg_idx)
                REG_CTRL: begin
                    rdata_d[CTRL_RST] = blk_reset_q;
                    rdata_d[CTRL_ENA] = conf_ena_q;
                end
                REG_CFG:    rdata_d = 32'(cfg_q);
                REG_IN:     rdata_d = 32'(in_q);
                REG_SETTLE: rdata_d = 32'(settle_q);
                REG_STATUS: begin
                    rdata_d[ST_BUSY]  = seq_busy;
                    rdata_d[ST_VALID] = seq_valid;
                    rdata_d[ST_ERR]   = err_q;
                end
                REG_OUT:    rdata_d = 32'(seq_out);
                default:    rdata_d = '0;
            endcase
        end
    end

    morphle_conf_seq #(
        .OUT_W     (OUT_W),
        .PULSE_CYC (PULSE_CYC),
        .SETTLE_W  (SETTLE_W)
    ) u_seq (
        .clk_i          (wb_clk_i),
        .rst_ni         (wb_rst_ni),
        .start_pulse_i  (start_pulse),
        .start_sample_i (start_sample),
        .settle_i       (settle_q),
        .clr_valid_i    (clr_valid),
        .ys_out_i       (ys_out),
        .confclk_o      (ys_confclk),
        .busy_o         (seq_busy),
        .valid_o        (seq_valid),
        .out_o          (seq_out)
    );

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdata_d;
    assign ys_reset   = blk_reset_q;
    assign ys_confena = conf_ena_q;
    assign ys_cfg     = cfg_q;
    assign ys_in      = in_q;
    assign busy_o     = seq_busy;

endmodule
